// File: rtl/ring_mod_carrier_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ring_mod_carrier_sequencer
// Brief    : Carrier divider selection for the ring modulator. Manual stepping
//            uses debounced keys; auto mode arpeggiates the 8-entry table.
// Revision : 1.0 - initial release
// ============================================================================
module ring_mod_carrier_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TEMPO_BASE      = 6250000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        key3,
   input  logic        key2,
   input  logic        sw_enable,
   input  logic        sw_auto,
   input  logic        sw_pingpong,
   input  logic [1:0]  tempo_sel,
   output logic [31:0] frequency,
   output logic        freq_valid,
   output logic [2:0]  step_index,
   output logic        disabled
);

   localparam int             DBW     = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] MODE_OFF    = 2'd0;
   localparam logic [1:0] MODE_MANUAL = 2'd1;
   localparam logic [1:0] MODE_AUTO   = 2'd2;

   logic [1:0]  w_keys;
   logic [1:0]  w_press;
   logic [1:0]  w_mode;
   logic [31:0] w_period;
   logic        w_tempo_hit;
   logic [2:0]  w_next;

   logic [1:0]  mode_q;
   logic [2:0]  idx_q, idx_d;
   logic        dir_q, dir_d;
   logic        paused_q, paused_d;
   logic [31:0] tempo_q, tempo_d;
   logic [31:0] freq_q;
   logic        valid_q;

   function automatic logic [31:0] carrier(input logic [2:0] idx);
      case (idx)
         3'd0:    carrier = 32'd4111;
         3'd1:    carrier = 32'd3551;
         3'd2:    carrier = 32'd3255;
         3'd3:    carrier = 32'd3063;
         3'd4:    carrier = 32'd2367;
         3'd5:    carrier = 32'd1791;
         3'd6:    carrier = 32'd1751;
         default: carrier = 32'd1591;
      endcase
   endfunction

   assign w_keys = {key3, key2};

   // Bit 1 is key3, bit 0 is key2; each yields a one-cycle pulse on a debounced fall.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_key
         logic           sync1_q, sync2_q, level_q, press_q;
         logic [DBW-1:0] cnt_q;

         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               sync1_q <= 1'b1;
               sync2_q <= 1'b1;
               level_q <= 1'b1;
               press_q <= 1'b0;
               cnt_q   <= '0;
            end else begin
               sync1_q <= w_keys[gi];
               sync2_q <= sync1_q;
               press_q <= 1'b0;
               if (sync2_q != level_q) begin
                  if (cnt_q == DB_LAST) begin
                     level_q <= sync2_q;
                     press_q <= ~sync2_q;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else begin
                  cnt_q <= '0;
               end
            end
         end

         assign w_press[gi] = press_q;
      end
   endgenerate

   always_comb begin
      w_mode = MODE_OFF;
      if (sw_enable) w_mode = sw_auto ? MODE_AUTO : MODE_MANUAL;
   end

   assign w_period    = 32'(TEMPO_BASE) << tempo_sel;
   assign w_tempo_hit = (tempo_q >= (w_period - 32'd1));

   // Pingpong bounces at the ends from the index alone, so a stale direction
   // left over from wrap mode still turns around at 7 or 0.
   always_comb begin
      w_next = idx_q + 3'd1;
      if (sw_pingpong) begin
         if (dir_q) w_next = (idx_q == 3'd7) ? 3'd6 : idx_q + 3'd1;
         else       w_next = (idx_q == 3'd0) ? 3'd1 : idx_q - 3'd1;
      end
   end

   always_comb begin
      idx_d    = idx_q;
      dir_d    = dir_q;
      paused_d = 1'b0;
      tempo_d  = '0;
      case (w_mode)
         MODE_MANUAL: begin
            if (w_press[0] && !w_press[1] && idx_q != 3'd7)
               idx_d = idx_q + 3'd1;
            else if (w_press[1] && !w_press[0] && idx_q != 3'd0)
               idx_d = idx_q - 3'd1;
         end
         MODE_AUTO: begin
            paused_d = paused_q;
            tempo_d  = tempo_q;
            if (w_press[1]) begin
               idx_d    = 3'd0;
               dir_d    = 1'b1;
               paused_d = 1'b0;
               tempo_d  = '0;
            end else begin
               if (w_press[0]) paused_d = ~paused_q;
               if (!paused_q) begin
                  if (w_tempo_hit) begin
                     tempo_d = '0;
                     idx_d   = w_next;
                     if (sw_pingpong) begin
                        if (w_next == 3'd7)      dir_d = 1'b0;
                        else if (w_next == 3'd0) dir_d = 1'b1;
                     end
                  end else begin
                     tempo_d = tempo_q + 32'd1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mode_q   <= MODE_OFF;
         idx_q    <= 3'd1;
         dir_q    <= 1'b1;
         paused_q <= 1'b0;
         tempo_q  <= '0;
         freq_q   <= 32'd3551;
         valid_q  <= 1'b0;
      end else begin
         mode_q   <= w_mode;
         idx_q    <= idx_d;
         dir_q    <= dir_d;
         paused_q <= paused_d;
         tempo_q  <= tempo_d;
         freq_q   <= carrier(idx_d);
         valid_q  <= (idx_d != idx_q);
      end
   end

   assign frequency  = freq_q;
   assign freq_valid = valid_q;
   assign step_index = idx_q;
   assign disabled   = (mode_q == MODE_OFF);

endmodule
`default_nettype wire

// File: tb/tb_ring_mod_carrier_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_mod_carrier_sequencer
// Brief    : Directed plus randomized checks against a table/arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_mod_carrier_sequencer;

   logic        CLK = 1'b0;
   logic        RST_N, key3, key2, sw_enable, sw_auto, sw_pingpong;
   logic [1:0]  tempo_sel;
   logic [31:0] frequency;
   logic        freq_valid;
   logic [2:0]  step_index;
   logic        disabled;

   int total  = 0;
   int bad    = 0;
   int cyc    = 0;
   int pulses = 0;
   int carrier [8] = '{4111, 3551, 3255, 3063, 2367, 1791, 1751, 1591};
   int m_idx, m_dir;

   ring_mod_carrier_sequencer #(.DEBOUNCE_CYCLES(4), .TEMPO_BASE(10)) dut (
      .CLK(CLK), .RST_N(RST_N), .key3(key3), .key2(key2),
      .sw_enable(sw_enable), .sw_auto(sw_auto), .sw_pingpong(sw_pingpong),
      .tempo_sel(tempo_sel), .frequency(frequency), .freq_valid(freq_valid),
      .step_index(step_index), .disabled(disabled)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      cyc++;
      #1;
      if (freq_valid === 1'b1) pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic hold_keys(input bit k3, input bit k2, input int lo, input int hi);
      key3 = ~k3;
      key2 = ~k2;
      tick(lo);
      key3 = 1'b1;
      key2 = 1'b1;
      tick(hi);
   endtask

   // Manual model: one press of each selected key, saturating at the table ends.
   task automatic manual_press(input bit k3, input bit k2);
      hold_keys(k3, k2, 8, 10);
      if (k2 && !k3 && m_idx < 7) m_idx++;
      else if (k3 && !k2 && m_idx > 0) m_idx--;
   endtask

   task automatic wait_pulse(input string tag, output int n);
      n = 0;
      do begin
         tick(1);
         n++;
      end while (freq_valid !== 1'b1 && n < 100);
      if (freq_valid !== 1'b1) check({tag, "_timeout"}, freq_valid, 1);
   endtask

   // Auto model: wrap adds one mod 8; pingpong reverses when the next step leaves 0..7.
   task automatic auto_step();
      if (sw_pingpong) begin
         if (m_idx + m_dir > 7 || m_idx + m_dir < 0) m_dir = -m_dir;
         m_idx = m_idx + m_dir;
      end else begin
         m_idx = (m_idx + 1) % 8;
      end
   endtask

   initial begin
      int n, p0, t0, ts, r;
      RST_N = 1'b0; key3 = 1'b1; key2 = 1'b1;
      sw_enable = 1'b0; sw_auto = 1'b0; sw_pingpong = 1'b0; tempo_sel = 2'd0;
      m_idx = 1; m_dir = 1;
      tick(3);
      check("rst_idx", step_index, 1);
      check("rst_freq", frequency, 3551);
      check("rst_dis", disabled, 1);
      check("rst_valid", freq_valid, 0);
      sw_enable = 1'b1;
      RST_N = 1'b1;
      #1 check("dis_before_edge", disabled, 1);
      tick(1);
      check("dis_after_edge", disabled, 0);

      // Debounce: short glitch rejected, long press yields exactly one step.
      p0 = pulses;
      hold_keys(1'b0, 1'b1, 3, 12);
      check("glitch_idx", step_index, m_idx);
      check("glitch_pulses", pulses - p0, 0);
      hold_keys(1'b0, 1'b1, 10, 10);
      m_idx = 2;
      check("db_idx", step_index, m_idx);
      check("db_freq", frequency, carrier[m_idx]);
      check("db_pulses", pulses - p0, 1);

      // Saturation at the top, then simultaneous presses.
      manual_press(1'b1, 1'b0);
      check("down_idx", step_index, m_idx);
      p0 = pulses;
      for (int i = 0; i < 8; i++) manual_press(1'b0, 1'b1);
      check("sat_idx", step_index, m_idx);
      check("sat_freq", frequency, carrier[m_idx]);
      check("sat_pulses", pulses - p0, 6);
      p0 = pulses;
      manual_press(1'b1, 1'b1);
      check("both_idx", step_index, m_idx);
      check("both_pulses", pulses - p0, 0);

      for (int i = 0; i < 12; i++) begin
         r = $urandom_range(0, 2);
         manual_press(r != 0, r != 1);
         check("rnd_man_idx", step_index, m_idx);
         check("rnd_man_freq", frequency, carrier[m_idx]);
      end

      // Auto wrap from 6.
      while (m_idx < 6) manual_press(1'b0, 1'b1);
      while (m_idx > 6) manual_press(1'b1, 1'b0);
      sw_auto = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_pulse("wrap", n);
         auto_step();
         check("wrap_int", n, 10);
         check("wrap_idx", step_index, m_idx);
         check("wrap_freq", frequency, carrier[m_idx]);
      end
      tempo_sel = 2'd2;
      wait_pulse("tempo2", n);
      auto_step();
      check("tempo2_int", n, 40);
      check("tempo2_idx", step_index, m_idx);
      for (int i = 0; i < 3; i++) begin
         ts = $urandom_range(0, 3);
         tempo_sel = 2'(ts);
         wait_pulse("rnd_tempo", n);
         auto_step();
         check("rnd_tempo_int", n, 10 << ts);
         check("rnd_tempo_idx", step_index, m_idx);
      end

      // Pingpong from 5.
      sw_auto = 1'b0;
      tempo_sel = 2'd0;
      while (m_idx < 5) manual_press(1'b0, 1'b1);
      while (m_idx > 5) manual_press(1'b1, 1'b0);
      check("pp_start", step_index, 5);
      sw_pingpong = 1'b1;
      sw_auto = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_pulse("pp", n);
         auto_step();
         check("pp_int", n, 10);
         check("pp_idx", step_index, m_idx);
         check("pp_freq", frequency, carrier[m_idx]);
      end

      // Pause for 25 cycles stretches the period to 35.
      p0 = cyc;
      key2 = 1'b0;
      t0 = cyc;
      tick(8);
      key2 = 1'b1;
      while (cyc < t0 + 25) tick(1);
      key2 = 1'b0;
      tick(8);
      key2 = 1'b1;
      wait_pulse("pause", n);
      auto_step();
      check("pause_int", cyc - p0, 35);
      check("pause_idx", step_index, m_idx);

      // Restart via key3.
      key3 = 1'b0;
      wait_pulse("restart", n);
      key3 = 1'b1;
      m_idx = 0;
      m_dir = 1;
      check("restart_idx", step_index, 0);
      check("restart_freq", frequency, 4111);
      wait_pulse("restart_next", n);
      auto_step();
      check("restart_int", n, 10);
      check("restart_next_idx", step_index, m_idx);

      // OFF holds everything; re-enable restarts a full period.
      sw_enable = 1'b0;
      tick(1);
      check("off_dis", disabled, 1);
      p0 = pulses;
      tick(50);
      manual_press(1'b0, 1'b1);
      manual_press(1'b1, 1'b0);
      m_idx = 1;
      check("off_idx", step_index, m_idx);
      check("off_pulses", pulses - p0, 0);
      sw_enable = 1'b1;
      wait_pulse("reen", n);
      auto_step();
      check("reen_int", n, 10);
      check("reen_idx", step_index, m_idx);
      check("reen_dis", disabled, 0);

      // Asynchronous reset mid-operation.
      tick(4);
      #2 RST_N = 1'b0;
      #1;
      check("mrst_idx", step_index, 1);
      check("mrst_freq", frequency, 3551);
      check("mrst_dis", disabled, 1);
      check("mrst_valid", freq_valid, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ring_mod_carrier_sequencer.md
Name: ring_mod_carrier_sequencer

Overview:
Generates the carrier divider value for the ring modulator. The value is chosen either manually with two debounced pushbuttons or by stepping automatically through the 8-entry carrier table at a switch-selected tempo, as an arpeggio. It sits between the board keys/switches and the ring-modulation datapath, and drives the datapath's frequency and disabled inputs.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized cycles before a key level is accepted (10 ms at 50 MHz)
TEMPO_BASE, 6250000, auto-step period in cycles at tempo_sel=0 (125 ms at 50 MHz)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
key3  in  1  pushbutton, active-low, asynchronous; step down / restart
key2  in  1  pushbutton, active-low, asynchronous; step up / pause
sw_enable  in  1  1 = effect enabled
sw_auto  in  1  1 = automatic sequencing, 0 = manual
sw_pingpong  in  1  auto pattern: 1 = bounce 0..7..0, 0 = wrap 7->0
tempo_sel  in  2  auto period = TEMPO_BASE << tempo_sel
frequency  out  32  carrier divider value for the ring modulator
freq_valid  out  1  one-cycle pulse; frequency just changed
step_index  out  3  current table index
disabled  out  1  1 = ring modulator bypassed

Behaviour:
- Clocking and reset: one clock (CLK). RST_N is asynchronous, active-low. Every register clears while RST_N=0, including during debounce or mid-period.
- Reset values:
  - step_index=1, frequency=3551, freq_valid=0, disabled=1.
  - Direction=up, paused=0.
  - Tempo counter=0, debounce counters=0, debounced key levels=1.
- Carrier table, indices 0..7: 4111, 3551, 3255, 3063, 2367, 1791, 1751, 1591.
  - frequency always equals table[step_index].
  - step_index and frequency update on the same edge.
  - freq_valid is high for the single cycle after any edge where step_index changed. There is no pulse if the index is unchanged.
- Key input path:
  - Each key passes through a 2-FF synchronizer.
  - A debounce counter runs while the synchronized value differs from the debounced level, and clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value.
  - A debounced 1->0 transition is a one-cycle press pulse. Release generates nothing.
- Mode state machine: OFF, MANUAL, AUTO, decoded every cycle.
  - OFF when sw_enable=0.
  - MANUAL when sw_enable=1 and sw_auto=0.
  - AUTO when sw_enable=1 and sw_auto=1.
  - disabled = 1 in OFF, else 0. disabled is registered: it changes one cycle after sw_enable changes.
- OFF:
  - Presses are ignored; step_index is held.
  - Tempo counter is held at 0; paused is cleared.
- MANUAL:
  - key3 press: step_index-1, saturating at 0.
  - key2 press: step_index+1, saturating at 7.
  - Both pressed in the same cycle: no change.
  - Pressing at a limit: no change, no freq_valid.
- AUTO:
  - While not paused, the tempo counter increments each cycle.
  - When counter >= (TEMPO_BASE<<tempo_sel)-1, the step advances and the counter returns to 0. A tempo_sel reduction mid-period therefore advances on the next cycle.
  - Wrap mode: step_index = (step_index+1) mod 8.
  - Pingpong mode: step by the direction. Direction flips to down on reaching 7 and to up on reaching 0, so 0,1..7,6..0,1.
  - key2 press toggles paused. While paused, the counter holds its value.
  - key3 press: step_index=0, direction=up, counter=0, paused=0. key3 has priority over a simultaneous tempo advance or key2 press.
  - In wrap mode the direction register is ignored. Switching to pingpong with step at 7 moves down next.
- Mode transitions:
  - Entering AUTO from any mode: counter=0, so the first advance comes a full period later.
  - Leaving AUTO: counter=0 and paused=0; step_index is kept.
- Widths and latency:
  - Tempo counter is 32 bits. Period comparison is done at 32 bits; TEMPO_BASE<<3 must fit.
  - Key latency: release-stable key falls at cycle N; press pulse at N+2+DEBOUNCE_CYCLES; step_index/frequency update at the next edge; freq_valid high the following cycle.

Test Plan:
1. Reset: assert RST_N=0 mid-operation -> frequency=3551, step_index=1, disabled=1, freq_valid=0 immediately; after release with sw_enable=1, disabled=0 after one cycle.
2. Debounce, with DEBOUNCE_CYCLES=4 in MANUAL: key2 low for 3 cycles then high -> no change. key2 low for 10 cycles -> exactly one step, 1->2, frequency=3255, one freq_valid pulse.
3. Manual saturation: 8 key2 presses from index 1 -> index 7, frequency=1591, exactly 6 freq_valid pulses. key3 held with key2 in the same cycle -> unchanged.
4. Auto wrap, with TEMPO_BASE=10, tempo_sel=0: starting at 6 -> indices 7, 0, 1 at 10-cycle intervals; frequencies 1591, 4111, 3551. tempo_sel=2 -> 40-cycle interval.
5. Auto pingpong: from 5 -> 6, 7, 6, 5, 4. A key2 press pauses for 25 cycles, resumes, and the next step lands at the remaining counter count. key3 press -> index 0, frequency 4111, next step to 1 after 10 cycles.
6. OFF: sw_enable=0 in AUTO -> disabled=1 next cycle; 50 cycles pass plus presses with no index change. Re-enable -> first advance exactly 10 cycles later.
